counter_sched: RTL

Round-robin scheduler that shares one up-counter instance between NUM_REQ requesters. Each requester asks for a count run from a start value. The scheduler grants one request at a time, loads the counter, and watches it count up to all-ones. It then signals completion to the owner. It sits directly in front of the counter and drives that counter's reset, load and data_in inputs.

---
 rtl/counter_sched.sv | 139 +++++++++++++
 1 files changed

// File: rtl/counter_sched.sv
// counter_sched: round-robin scheduler that time-shares one external up-counter
// between NUM_REQ requesters. A granted requester's start value is loaded into
// the counter, which then runs up to all-ones; the owner gets a one-cycle done
// pulse and the next arbitration starts just after the last winner.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   req_valid  per-requester request
//   req_start  flattened start values, requester i at [i*CNT_WIDTH +: CNT_WIDTH]
//   req_ready  one-hot acceptance (IDLE only, combinational on req_valid)
//   req_done   one-cycle completion pulse to the owner
//   busy       high while loading or running the counter
//   grant_id   index of the current/last owner
//   cnt_clear  counter active-high reset (parks it at 0 while idle)
//   cnt_load   counter load strobe
//   cnt_data   counter load data
//   cnt_count  counter output
module counter_sched #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*CNT_WIDTH-1:0]   req_start,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             req_done,
    output logic                           busy,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id,
    output logic                           cnt_clear,
    output logic                           cnt_load,
    output logic [CNT_WIDTH-1:0]           cnt_data,
    input  logic [CNT_WIDTH-1:0]           cnt_count
);

    localparam int unsigned IDW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t               state;
    logic [IDW-1:0]       rr_ptr;
    logic [CNT_WIDTH-1:0] start_q;

    logic                 win_found;
    logic [IDW-1:0]       win_idx;
    logic [IDW-1:0]       scan_idx;
    logic                 run_end;
    logic [IDW-1:0]       next_ptr;

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan_idx = IDW'((32'(rr_ptr) + k) % NUM_REQ);
            if (!win_found && req_valid[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    assign run_end  = (state == S_RUN) && (cnt_count == '1);
    // Pointer just past the finishing owner, so it gets lowest priority next.
    assign next_ptr = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + IDW'(1);

    // Output decode from state and registers; reset forces the quiet values.
    always_comb begin
        req_ready = '0;
        req_done  = '0;
        busy      = 1'b0;
        cnt_clear = 1'b1;
        cnt_load  = 1'b0;
        cnt_data  = start_q;
        if (!reset) begin
            cnt_data = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        req_ready[win_idx] = 1'b1;
                    end
                end
                S_LOAD: begin
                    busy      = 1'b1;
                    cnt_clear = 1'b0;
                    cnt_load  = 1'b1;
                end
                S_RUN: begin
                    busy      = 1'b1;
                    cnt_clear = 1'b0;
                    if (run_end) begin
                        req_done[grant_id] = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // State machine and grant bookkeeping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            start_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        start_q  <= req_start[32'(win_idx) * CNT_WIDTH +: CNT_WIDTH];
                        grant_id <= win_idx;
                        state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    state <= S_RUN;
                end
                S_RUN: begin
                    if (run_end) begin
                        rr_ptr <= next_ptr;
                        state  <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
